// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - parallel-to-serial frame transmitter, LSB first
//
// Parameters:
//   DATA_W        data bits per frame (1..32)
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   tx_valid  producer has a word on tx_data
//   tx_data   word to send, sampled only at acceptance
//   tx_ready  block can accept a word (registered)
//   tx_out    serial line, idle high (registered)
//   busy      a frame is in progress (registered)
// Build option:
//   SERIAL_TX_PARITY_EN  inserts an even-parity bit between the data and stop bits
module serial_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ready,
   output logic              tx_out,
   output logic              busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } state_t;

   state_t            state, state_n;
   logic [CW-1:0]     cyc, cyc_n;
   logic [BW-1:0]     bit_cnt, bit_n;
   logic [DATA_W-1:0] shift, shift_n, shifted;
   logic              tx_out_n, tx_ready_n, busy_n;
`ifdef SERIAL_TX_PARITY_EN
   logic              par_q, par_n;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cyc      <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         tx_out   <= 1'b1;
         tx_ready <= 1'b1;
         busy     <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         state    <= state_n;
         cyc      <= cyc_n;
         bit_cnt  <= bit_n;
         shift    <= shift_n;
         tx_out   <= tx_out_n;
         tx_ready <= tx_ready_n;
         busy     <= busy_n;
`ifdef SERIAL_TX_PARITY_EN
         par_q    <= par_n;
`endif
      end
   end

   // All outputs are computed one cycle ahead so that they leave the flops
   // exactly at the bit boundaries.
   always_comb begin
      state_n    = state;
      cyc_n      = cyc;
      bit_n      = bit_cnt;
      shift_n    = shift;
      tx_out_n   = tx_out;
      tx_ready_n = tx_ready;
      busy_n     = busy;
      shifted    = shift >> 1;
`ifdef SERIAL_TX_PARITY_EN
      par_n      = par_q;
`endif
      case (state)
         IDLE: begin
            if (tx_valid && tx_ready) begin
               state_n    = START;
               shift_n    = tx_data;
               cyc_n      = '0;
               bit_n      = '0;
               tx_out_n   = 1'b0;
               tx_ready_n = 1'b0;
               busy_n     = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
               // Parity is taken from the accepted word, before any shifting.
               par_n      = ^tx_data;
`endif
            end
         end
         START: begin
            if (cyc == CYC_LAST) begin
               cyc_n    = '0;
               state_n  = DATA;
               tx_out_n = shift[0];
            end else begin
               cyc_n = cyc + 1'b1;
            end
         end
         DATA: begin
            if (cyc == CYC_LAST) begin
               cyc_n   = '0;
               shift_n = shifted;
               bit_n   = bit_cnt + 1'b1;
               if (bit_cnt == BIT_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                  state_n  = PARITY;
                  tx_out_n = par_q;
`else
                  state_n  = STOP;
                  tx_out_n = 1'b1;
`endif
               end else begin
                  // Next bit is read from the post-shift value so DATA_W=1 stays in range.
                  tx_out_n = shifted[0];
               end
            end else begin
               cyc_n = cyc + 1'b1;
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         PARITY: begin
            if (cyc == CYC_LAST) begin
               cyc_n    = '0;
               state_n  = STOP;
               tx_out_n = 1'b1;
            end else begin
               cyc_n = cyc + 1'b1;
            end
         end
`endif
         STOP: begin
            if (cyc == CYC_LAST) begin
               cyc_n      = '0;
               state_n    = IDLE;
               tx_out_n   = 1'b1;
               tx_ready_n = 1'b1;
               busy_n     = 1'b0;
            end else begin
               cyc_n = cyc + 1'b1;
            end
         end
         default: begin
            state_n    = IDLE;
            cyc_n      = '0;
            tx_out_n   = 1'b1;
            tx_ready_n = 1'b1;
            busy_n     = 1'b0;
         end
      endcase
   end

endmodule
